// File: rtl/kernel_pr_hls_deadlock_confirm_unit.sv
// Deadlock confirmation for one process: merges incoming dependence vectors, forwards tokens,
// and confirms a deadlock after CONFIRM_CYCLES consecutive self-dependence cycles.
module kernel_pr_hls_deadlock_confirm_unit #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            dl_ack,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_confirmed,
    output logic [PROC_NUM-1:0]             dl_cycle_vec,
    output logic [CNT_W-1:0]                confirm_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WATCH     = 2'd1,
        CONFIRMED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]    CONF_CNT = CNT_W'(CONFIRM_CYCLES);
    localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;

    state_t                    state_q, state_d;
    logic [PROC_NUM-1:0]       dep_merged, dep;
    logic [PROC_NUM-1:0]       dep_reg_q, dep_reg_d;
    logic [PROC_NUM-1:0]       dl_cycle_q, dl_cycle_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      detect_q, detect_d;
    logic [OUT_CHAN_NUM-1:0]   token_q, token_d;
    logic                      upd, hold, any_blk, any_tok, fwd, in_confirmed;

    always_comb begin
        dep_merged = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            dep_merged = dep_merged |
                (in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM] & {PROC_NUM{in_chan_dep_vld_vec[i]}});
        end
    end

    // Once a deadlock is globally flagged, only token-carrying cycles may refresh the vector.
    assign upd          = ~dl_detect_in | (|token_in_vec);
    assign dep          = upd ? dep_merged : dep_reg_q;
    assign any_blk      = |proc_dep_vld_vec;
    assign any_tok      = |token_in_vec;
    assign hold         = upd & dep[PROC_ID] & any_blk;
    assign in_confirmed = (state_q == CONFIRMED);
    assign fwd          = ((any_tok & ~token_clear) | origin) & ~in_confirmed;
    assign dep_reg_d    = any_blk ? dep : '0;
    assign token_d      = fwd ? proc_dep_vld_vec : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            dep_reg_q  <= '0;
            dl_cycle_q <= '0;
            cnt_q      <= '0;
            detect_q   <= 1'b0;
            token_q    <= '0;
        end else begin
            state_q    <= state_d;
            dep_reg_q  <= dep_reg_d;
            dl_cycle_q <= dl_cycle_d;
            cnt_q      <= cnt_d;
            detect_q   <= detect_d;
            token_q    <= token_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hold) begin
                    state_d = (CONFIRM_CYCLES == 1) ? CONFIRMED : WATCH;
                end
            end
            WATCH: begin
                if (!hold) begin
                    state_d = IDLE;
                end else if (cnt_q + CNT_W'(1) == CONF_CNT) begin
                    state_d = CONFIRMED;
                end
            end
            CONFIRMED: begin
                if (dl_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        dl_cycle_d = dl_cycle_q;
        detect_d   = 1'b0;
        case (state_q)
            IDLE:  cnt_d = hold ? CNT_W'(1) : '0;
            WATCH: cnt_d = hold ? cnt_q + CNT_W'(1) : '0;
            CONFIRMED: begin
                if (dl_ack) begin
                    cnt_d      = '0;
                    dl_cycle_d = '0;
                end
            end
            default: cnt_d = '0;
        endcase
        // Entry into CONFIRMED: snapshot the vector that closed the loop and saturate the count.
        if (state_q != CONFIRMED && state_d == CONFIRMED) begin
            detect_d   = 1'b1;
            dl_cycle_d = dep;
            cnt_d      = CONF_CNT;
        end
    end

    always_comb begin
        out_chan_dep_vld_vec = proc_dep_vld_vec;
        out_chan_dep_data    = dep_reg_q | SELF_BIT;
        token_out_vec        = token_q;
        dl_detect_out        = detect_q;
        dl_confirmed         = in_confirmed;
        dl_cycle_vec         = dl_cycle_q;
        confirm_cnt          = cnt_q;
    end

endmodule

// File: tb/tb_kernel_pr_hls_deadlock_confirm_unit.sv
// Directed bench: streak-count reference model checked every cycle plus literal spot checks.
module tb_kernel_pr_hls_deadlock_confirm_unit;

    localparam int PN = 4;
    localparam int PID = 1;
    localparam int IN_N = 2;
    localparam int OUT_N = 3;
    localparam int CC = 4;
    localparam int CW = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [OUT_N-1:0]      proc_dep_vld_vec;
    logic [IN_N-1:0]       in_chan_dep_vld_vec;
    logic [IN_N*PN-1:0]    in_chan_dep_data_vec;
    logic [IN_N-1:0]       token_in_vec;
    logic                  dl_detect_in, origin, token_clear, dl_ack;
    logic [OUT_N-1:0]      out_chan_dep_vld_vec;
    logic [PN-1:0]         out_chan_dep_data;
    logic [OUT_N-1:0]      token_out_vec;
    logic                  dl_detect_out, dl_confirmed;
    logic [PN-1:0]         dl_cycle_vec;
    logic [CW-1:0]         confirm_cnt;

    int checks = 0;
    int failures = 0;

    kernel_pr_hls_deadlock_confirm_unit #(
        .PROC_NUM(PN), .PROC_ID(PID), .IN_CHAN_NUM(IN_N), .OUT_CHAN_NUM(OUT_N),
        .CONFIRM_CYCLES(CC), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset),
        .proc_dep_vld_vec(proc_dep_vld_vec),
        .in_chan_dep_vld_vec(in_chan_dep_vld_vec),
        .in_chan_dep_data_vec(in_chan_dep_data_vec),
        .token_in_vec(token_in_vec),
        .dl_detect_in(dl_detect_in), .origin(origin),
        .token_clear(token_clear), .dl_ack(dl_ack),
        .out_chan_dep_vld_vec(out_chan_dep_vld_vec),
        .out_chan_dep_data(out_chan_dep_data),
        .token_out_vec(token_out_vec),
        .dl_detect_out(dl_detect_out), .dl_confirmed(dl_confirmed),
        .dl_cycle_vec(dl_cycle_vec), .confirm_cnt(confirm_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: consecutive-hold streak, sticky confirmation, snapshot and token forwarding.
    logic [PN-1:0]    m_dep_reg = '0;
    logic [PN-1:0]    m_cycle = '0;
    logic [OUT_N-1:0] m_tok = '0;
    int               m_streak = 0;
    bit               m_conf = 0;
    bit               m_pulse = 0;
    bit               run = 0;

    always @(posedge clock) begin
        logic [PN-1:0] merged, dep;
        bit u, h;
        merged = '0;
        for (int i = 0; i < IN_N; i++)
            if (in_chan_dep_vld_vec[i]) merged = merged | in_chan_dep_data_vec[i*PN +: PN];
        u   = !dl_detect_in || (token_in_vec != 0);
        dep = u ? merged : m_dep_reg;
        h   = u && dep[PID] && (proc_dep_vld_vec != 0);
        if (reset) begin
            m_dep_reg = '0; m_cycle = '0; m_tok = '0;
            m_streak = 0; m_conf = 0; m_pulse = 0;
        end else begin
            m_tok = ((((token_in_vec != 0) && !token_clear) || origin) && !m_conf) ? proc_dep_vld_vec : '0;
            m_pulse = 0;
            if (m_conf) begin
                if (dl_ack) begin
                    m_conf = 0; m_streak = 0; m_cycle = '0;
                end
            end else if (h) begin
                m_streak++;
                if (m_streak == CC) begin
                    m_conf = 1; m_pulse = 1; m_cycle = dep;
                end
            end else begin
                m_streak = 0;
            end
            m_dep_reg = (proc_dep_vld_vec != 0) ? dep : '0;
        end
        run = 1;
    end

    always @(negedge clock) begin
        if (run) begin
            chk("m_out_vld", 32'(out_chan_dep_vld_vec), 32'(proc_dep_vld_vec));
            chk("m_out_data", 32'(out_chan_dep_data), 32'(m_dep_reg | 4'b0010));
            chk("m_token", 32'(token_out_vec), 32'(m_tok));
            chk("m_pulse", 32'(dl_detect_out), 32'(m_pulse));
            chk("m_conf", 32'(dl_confirmed), 32'(m_conf));
            chk("m_cycle", 32'(dl_cycle_vec), 32'(m_cycle));
            chk("m_cnt", 32'(confirm_cnt), 32'(m_streak));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic idle_in();
        proc_dep_vld_vec = '0; in_chan_dep_vld_vec = '0; in_chan_dep_data_vec = '0;
        token_in_vec = '0; dl_detect_in = 0; origin = 0; token_clear = 0; dl_ack = 0;
    endtask

    // Self-dependence through channel 0; channel 1 carries data but is not valid.
    task automatic set_stim();
        idle_in();
        proc_dep_vld_vec = 3'b001;
        in_chan_dep_vld_vec = 2'b01;
        in_chan_dep_data_vec = {4'b1000, 4'b0010};
    endtask

    initial begin
        idle_in();
        reset = 1;
        tick(2);
        chk("rst_cnt", 32'(confirm_cnt), 0);
        chk("rst_conf", 32'(dl_confirmed), 0);
        chk("rst_data", 32'(out_chan_dep_data), 32'h2);
        chk("rst_tok", 32'(token_out_vec), 0);
        reset = 0;
        tick(1);

        // Full confirmation after four hold cycles
        set_stim();
        tick(3);
        chk("s1_cnt3", 32'(confirm_cnt), 3);
        chk("s1_nopulse", 32'(dl_detect_out), 0);
        tick(1);
        chk("s1_pulse", 32'(dl_detect_out), 1);
        chk("s1_cycle", 32'(dl_cycle_vec), 32'h2);
        chk("s1_cnt_sat", 32'(confirm_cnt), 4);
        tick(1);
        chk("s1_pulse_gone", 32'(dl_detect_out), 0);
        chk("s1_sticky", 32'(dl_confirmed), 1);
        dl_ack = 1;
        tick(1);
        chk("ack_conf", 32'(dl_confirmed), 0);
        chk("ack_cycle", 32'(dl_cycle_vec), 0);
        chk("ack_cnt", 32'(confirm_cnt), 0);
        idle_in();
        tick(2);

        // Hold breaks after two cycles
        set_stim();
        tick(2);
        chk("s2_cnt2", 32'(confirm_cnt), 2);
        proc_dep_vld_vec = '0;
        tick(1);
        chk("s2_cnt0", 32'(confirm_cnt), 0);
        tick(4);
        idle_in();
        tick(1);

        // Global detect without tokens freezes the vector and kills hold
        set_stim();
        tick(2);
        dl_detect_in = 1;
        tick(1);
        chk("s3a_cnt0", 32'(confirm_cnt), 0);
        idle_in();
        tick(1);

        // Global detect with a token keeps the count going
        set_stim();
        tick(2);
        dl_detect_in = 1;
        token_in_vec = 2'b01;
        tick(2);
        chk("s3b_pulse", 32'(dl_detect_out), 1);
        chk("s3b_tok", 32'(token_out_vec), 32'h1);
        tick(1);
        chk("s3b_tok_conf", 32'(token_out_vec), 0);
        dl_ack = 1;
        tick(1);
        idle_in();
        tick(1);

        // Token forwarding
        origin = 1;
        proc_dep_vld_vec = 3'b101;
        tick(1);
        chk("s4_origin", 32'(token_out_vec), 32'h5);
        origin = 0; token_in_vec = 2'b01; token_clear = 1;
        tick(1);
        chk("s4_clear", 32'(token_out_vec), 0);
        origin = 1;
        tick(1);
        chk("s4_origin_wins", 32'(token_out_vec), 32'h5);
        origin = 0; token_clear = 0; token_in_vec = 2'b10; proc_dep_vld_vec = 3'b110;
        tick(1);
        chk("s4_fwd", 32'(token_out_vec), 32'h6);
        idle_in();
        tick(1);

        // Two valid channels merged, no self bit
        proc_dep_vld_vec = 3'b010;
        in_chan_dep_vld_vec = 2'b11;
        in_chan_dep_data_vec = {4'b0100, 4'b0001};
        tick(1);
        chk("s5_merge", 32'(out_chan_dep_data), 32'h7);
        chk("s5_nohold", 32'(confirm_cnt), 0);
        // Self-dependence via channel 1 only; channel 0 masked
        in_chan_dep_vld_vec = 2'b10;
        in_chan_dep_data_vec = {4'b1010, 4'b0001};
        proc_dep_vld_vec = 3'b100;
        tick(4);
        chk("s5_pulse", 32'(dl_detect_out), 1);
        chk("s5_cycle", 32'(dl_cycle_vec), 32'hA);
        dl_ack = 1;
        tick(1);
        idle_in();
        tick(1);

        // Reset mid-WATCH and in CONFIRMED
        set_stim();
        tick(2);
        chk("s6_cnt2", 32'(confirm_cnt), 2);
        reset = 1;
        tick(1);
        chk("s6_rst_cnt", 32'(confirm_cnt), 0);
        chk("s6_rst_conf", 32'(dl_confirmed), 0);
        reset = 0;
        idle_in();
        tick(6);
        set_stim();
        tick(4);
        chk("s6_pulse", 32'(dl_detect_out), 1);
        reset = 1;
        tick(1);
        chk("s6_rst_conf2", 32'(dl_confirmed), 0);
        chk("s6_rst_cycle", 32'(dl_cycle_vec), 0);
        reset = 0;
        idle_in();
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
